resource_lock_arbiter: RTL

//  Oldest-first lock arbiter sharing NUM_RES identical resources (ALU pool, mem banks) among NUM_PORTS SICs.
//  A SIC requests with its issue ID; arbiter grants a free resource, holds the lock until the request drops.

---
 rtl/resource_lock_arbiter_pkg.sv | 21 ++
 rtl/resource_lock_arbiter_oldest_rank_picker.sv | 61 ++++++
 rtl/resource_lock_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/resource_lock_arbiter_pkg.sv
// Shared types and age compare for the resource lock arbiter and its issue-side neighbours.
// Optional feature macro used by the arbiter: RES_ARB_TIMEOUT_EN (forced release of long-held locks).
package resource_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        OWN     = 2'd2,
        BLOCKED = 2'd3
    } arb_port_state_e;

    localparam int ARB_HOLD_CNT_W = 16;

    // Wrap-around age compare: a is older than b when the msb-wide difference a-b is negative.
    function automatic logic id_older(input logic [63:0] a, input logic [63:0] b, input logic [5:0] msb);
        logic [63:0] w_diff;
        w_diff = a - b;
        return w_diff[msb];
    endfunction

endpackage

// File: rtl/resource_lock_arbiter_oldest_rank_picker.sv
// Combinational allocation helper: ranks eligible ports by age and maps rank k to the k-th free resource.
module resource_lock_arbiter_oldest_rank_picker
    import resource_lock_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int NUM_RES   = 8,
    parameter int ID_WIDTH  = 16,
    parameter int RES_W     = 3
) (
    input  logic [NUM_PORTS-1:0]               i_elig,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] i_id,
    input  logic [NUM_RES-1:0]                 i_free,
    output logic [NUM_PORTS-1:0]               o_alloc,
    output logic [NUM_PORTS-1:0][RES_W-1:0]    o_res_idx
);

    localparam int MAX_N = (NUM_PORTS > NUM_RES) ? NUM_PORTS : NUM_RES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    logic [CNT_W-1:0]                        w_free_cnt;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     w_older;
    logic [NUM_PORTS-1:0][CNT_W-1:0]         w_rank;
    logic [NUM_PORTS-1:0][CNT_W-1:0]         w_seen;

    // Free resources at the start of the cycle.
    always_comb begin
        w_free_cnt = '0;
        for (int r = 0; r < NUM_RES; r++) begin
            w_free_cnt = w_free_cnt + CNT_W'(i_free[r]);
        end
    end

    // w_older[p][q]: q competes this cycle and beats p on age (ties go to the lower port).
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                w_older[p][q] = (q != p) && i_elig[q] &&
                    ((i_id[q] == i_id[p]) ? (q < p)
                                          : id_older(64'(i_id[q]), 64'(i_id[p]), 6'(ID_WIDTH - 1)));
            end
        end
    end

    // Rank is the count of older competitors; rank k takes the k-th lowest free index.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rank[p] = '0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                w_rank[p] = w_rank[p] + CNT_W'(w_older[p][q]);
            end
            o_alloc[p]   = i_elig[p] && (w_rank[p] < w_free_cnt);
            o_res_idx[p] = '0;
            w_seen[p]    = '0;
            for (int r = 0; r < NUM_RES; r++) begin
                o_res_idx[p] = (i_free[r] && (w_seen[p] == w_rank[p])) ? RES_W'(r) : o_res_idx[p];
                w_seen[p]    = w_seen[p] + CNT_W'(i_free[r]);
            end
        end
    end

endmodule

// File: rtl/resource_lock_arbiter.sv
// Oldest-first lock arbiter: per-port FSMs and the resource lock table.
// Build option RES_ARB_TIMEOUT_EN adds per-resource hold counters with forced release.
module resource_lock_arbiter
    import resource_lock_arbiter_pkg::*;
#(
    parameter int  NUM_PORTS    = 8,
    parameter int  NUM_RES      = 8,
    parameter int  ID_WIDTH     = 16,
    parameter int  LOCK_TIMEOUT = 255,
    localparam int RES_W        = (NUM_RES > 1) ? $clog2(NUM_RES) : 1,
    localparam int PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_flush,
    input  logic [NUM_PORTS-1:0]               i_req_valid,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] i_req_id,
    output logic [NUM_PORTS-1:0]               o_grant,
    output logic [NUM_PORTS-1:0][RES_W-1:0]    o_grant_res,
    output logic [NUM_RES-1:0]                 o_res_busy,
    output logic [NUM_RES-1:0][PORT_W-1:0]     o_res_owner,
    output logic [NUM_PORTS-1:0]               o_timeout_pulse
);

    if ((LOCK_TIMEOUT < 1) || (LOCK_TIMEOUT > 65535) || (ID_WIDTH < 1) || (ID_WIDTH > 64)) begin : g_param_check
        $error("resource_lock_arbiter: parameter out of range");
    end

    arb_port_state_e                 r_state [NUM_PORTS];
    logic [NUM_PORTS-1:0]            r_grant;
    logic [NUM_PORTS-1:0][RES_W-1:0] r_grant_res;
    logic [NUM_RES-1:0]              r_res_busy;
    logic [NUM_RES-1:0][PORT_W-1:0]  r_res_owner;
    logic [NUM_PORTS-1:0]            r_timeout_pulse;

    logic [NUM_PORTS-1:0]            w_elig;
    logic [NUM_PORTS-1:0]            w_alloc;
    logic [NUM_PORTS-1:0]            w_timeout;
    logic [NUM_PORTS-1:0]            w_release;
    logic [NUM_PORTS-1:0][RES_W-1:0] w_alloc_res;

    // Only idle/waiting ports still requesting compete; owners are never preempted.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_elig[p]    = i_req_valid[p] && ((r_state[p] == IDLE) || (r_state[p] == WAIT));
            w_release[p] = (r_state[p] == OWN) && (!i_req_valid[p] || w_timeout[p]);
        end
    end

    resource_lock_arbiter_oldest_rank_picker #(
        .NUM_PORTS (NUM_PORTS),
        .NUM_RES   (NUM_RES),
        .ID_WIDTH  (ID_WIDTH),
        .RES_W     (RES_W)
    ) u_picker (
        .i_elig    (w_elig),
        .i_id      (i_req_id),
        .i_free    (~r_res_busy),
        .o_alloc   (w_alloc),
        .o_res_idx (w_alloc_res)
    );

`ifdef RES_ARB_TIMEOUT_EN
    logic [NUM_RES-1:0][ARB_HOLD_CNT_W-1:0] r_hold_cnt;

    // Counter sits at 0 while free, so it reads 0 on the first held cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold_cnt <= '0;
        end else if (i_flush) begin
            r_hold_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_RES; r++) begin
                r_hold_cnt[r] <= r_res_busy[r] ? (r_hold_cnt[r] + 16'd1) : 16'd0;
            end
        end
    end

    // Owner still requesting on its last permitted cycle is force-released at the next edge.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_timeout[p] = (r_state[p] == OWN) && i_req_valid[p] &&
                           (r_hold_cnt[r_grant_res[p]] == 16'(LOCK_TIMEOUT - 1));
        end
    end
`else
    assign w_timeout = '0;
`endif

    // Port FSMs and lock table; flush overrides any allocation in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_flush) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_state[p] <= IDLE;
            end
            r_grant         <= '0;
            r_grant_res     <= '0;
            r_res_busy      <= '0;
            r_res_owner     <= '0;
            r_timeout_pulse <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_timeout_pulse[p] <= 1'b0;
                case (r_state[p])
                    IDLE, WAIT: begin
                        if (!i_req_valid[p]) begin
                            r_state[p] <= IDLE;
                        end else if (w_alloc[p]) begin
                            r_state[p]     <= OWN;
                            r_grant[p]     <= 1'b1;
                            r_grant_res[p] <= w_alloc_res[p];
                        end else begin
                            r_state[p] <= WAIT;
                        end
                    end
                    OWN: begin
                        if (!i_req_valid[p]) begin
                            r_state[p]     <= IDLE;
                            r_grant[p]     <= 1'b0;
                            r_grant_res[p] <= '0;
                        end else if (w_timeout[p]) begin
                            r_state[p]         <= BLOCKED;
                            r_grant[p]         <= 1'b0;
                            r_grant_res[p]     <= '0;
                            r_timeout_pulse[p] <= 1'b1;
                        end else begin
                            r_state[p] <= OWN;
                        end
                    end
                    BLOCKED: begin
                        r_state[p] <= i_req_valid[p] ? BLOCKED : IDLE;
                    end
                    default: begin
                        r_state[p]     <= IDLE;
                        r_grant[p]     <= 1'b0;
                        r_grant_res[p] <= '0;
                    end
                endcase
                if (w_release[p]) begin
                    r_res_busy[r_grant_res[p]]  <= 1'b0;
                    r_res_owner[r_grant_res[p]] <= '0;
                end
                if (w_alloc[p]) begin
                    r_res_busy[w_alloc_res[p]]  <= 1'b1;
                    r_res_owner[w_alloc_res[p]] <= PORT_W'(p);
                end
            end
        end
    end

    assign o_grant         = r_grant;
    assign o_grant_res     = r_grant_res;
    assign o_res_busy      = r_res_busy;
    assign o_res_owner     = r_res_owner;
    assign o_timeout_pulse = r_timeout_pulse;

endmodule
